neuron_lut_loader: RTL and testbench



---
 rtl/neuron_lut_loader.sv | 124 ++++++++++++
 tb/tb_neuron_lut_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_lut_loader.sv
// neuron_lut_loader
//   Runtime-reprogrammable LUT neuron. A truth table arrives as a serialized
//   valid/ready stream (entry 0 first, LSB first within each beat). It is
//   written into a 2^IN_BITS x OUT_BITS distributed RAM and then serves
//   registered lookups with the same semantics as a fixed-ROM neuron.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   cfg_valid/cfg_ready    config beat handshake
//   cfg_data, cfg_last     beat payload, final-beat marker
//   tbl_loaded             level: complete table resident, lookups enabled
//   cfg_err                one-cycle pulse on a framing error
//   in_valid, in_data      lookup request and address
//   out_valid, out_data    lookup result, one cycle after the request
module neuron_lut_loader #(
  parameter int IN_BITS   = 6,
  parameter int OUT_BITS  = 1,
  parameter int CFG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CFG_WIDTH-1:0] cfg_data,
  input  logic                 cfg_last,
  output logic                 tbl_loaded,
  output logic                 cfg_err,
  input  logic                 in_valid,
  input  logic [IN_BITS-1:0]   in_data,
  output logic                 out_valid,
  output logic [OUT_BITS-1:0]  out_data
);

  localparam int TBL_BITS = (2 ** IN_BITS) * OUT_BITS;
  localparam int NBEATS   = TBL_BITS / CFG_WIDTH;
  localparam int CW       = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  generate
    if ((TBL_BITS % CFG_WIDTH) != 0) begin : g_bad_cfg_width
      $error("neuron_lut_loader: table size must be a multiple of CFG_WIDTH");
    end
  endgenerate

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]          state;
  logic [CW-1:0]       beat_cnt;
  logic [TBL_BITS-1:0] tbl;

  logic                accept;
  logic [CW-1:0]       wr_idx;
  logic                last_slot;
  logic [OUT_BITS-1:0] rd_entry;

  assign accept = cfg_valid & cfg_ready;

  // A beat accepted outside LOAD always starts a new table at slot 0, so
  // EMPTY and RUN share the LOAD framing rules with the slot forced to 0.
  assign wr_idx    = (state == S_LOAD) ? beat_cnt : '0;
  assign last_slot = (wr_idx == CW'(NBEATS - 1));

  // Asynchronous read; the result is registered into out_data below.
  assign rd_entry = tbl[int'(in_data) * OUT_BITS +: OUT_BITS];

  // Table storage: no reset, write-only from the config stream.
  always_ff @(posedge clk) begin
    if (accept) begin
      tbl[int'(wr_idx) * CFG_WIDTH +: CFG_WIDTH] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      beat_cnt   <= '0;
      cfg_ready  <= 1'b0;
      tbl_loaded <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      if (state == S_LOAD || state == S_EMPTY || state == S_RUN) begin
        if (accept) begin
          if (last_slot && cfg_last) begin
            state      <= S_RUN;
            beat_cnt   <= '0;
            tbl_loaded <= 1'b1;
          end else if (last_slot || cfg_last) begin
            // Framing error: partial contents stay in RAM but are unusable.
            state      <= S_EMPTY;
            beat_cnt   <= '0;
            tbl_loaded <= 1'b0;
            cfg_err    <= 1'b1;
          end else begin
            state      <= S_LOAD;
            beat_cnt   <= CW'(wr_idx + 1'b1);
            tbl_loaded <= 1'b0;
          end
        end
      end else begin
        state      <= S_EMPTY;
        beat_cnt   <= '0;
        tbl_loaded <= 1'b0;
      end
    end
  end

  // Lookup uses tbl_loaded of the request cycle, so a lookup issued with a
  // reload's first beat still sees the old table (the write lands at the edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid & tbl_loaded;
      if (in_valid && tbl_loaded) begin
        out_data <= rd_entry;
      end
    end
  end

endmodule

// File: tb/tb_neuron_lut_loader.sv
// tb_neuron_lut_loader
//   Scoreboard bench for neuron_lut_loader at default parameters. The driver
//   keeps a bit-array model of the table and a count of beats in the current
//   frame; expected lookup results are queued and a negedge monitor pops them
//   whenever the DUT presents out_valid.
module tb_neuron_lut_loader;

  localparam int NB = 8;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       tbl_loaded;
  logic       cfg_err;
  logic       in_valid;
  logic [5:0] in_data;
  logic       out_valid;
  logic [0:0] out_data;

  neuron_lut_loader #(.IN_BITS(6), .OUT_BITS(1), .CFG_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last),
    .tbl_loaded(tbl_loaded), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;

  bit [63:0] mtbl;
  int        mcnt;
  bit        mloaded;
  bit        expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every presented result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("out_valid_unexpected", out_valid, 0);
      end else begin
        chk("out_data", out_data, expq.pop_front());
      end
    end
  end

  // One clock of stimulus. The model decides the lookup outcome from the
  // state before this cycle's beat, then applies the beat.
  task automatic step(input bit cv, input logic [7:0] d, input bit last,
                      input bit iv, input logic [5:0] a);
    bit exp_err;
    exp_err   = 1'b0;
    cfg_valid = cv;
    cfg_data  = d;
    cfg_last  = last;
    in_valid  = iv;
    in_data   = a;
    if (iv && mloaded) expq.push_back(mtbl[a]);
    if (cv) begin
      for (int j = 0; j < 8; j++) mtbl[mcnt*8 + j] = d[j];
      mcnt++;
      if (last || mcnt == NB) begin
        if (last && mcnt == NB) mloaded = 1'b1;
        else begin
          mloaded = 1'b0;
          exp_err = 1'b1;
        end
        mcnt = 0;
      end else begin
        mloaded = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("tbl_loaded", tbl_loaded, mloaded);
    chk("cfg_err", cfg_err, exp_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'($urandom), 1'b0, 6'($urandom));
  endtask

  // Sends nb beats of v (beat 0 in v[7:0]); cfg_last only on beat last_pos.
  task automatic load(input logic [63:0] v, input int last_pos, input int nb, input bit gaps);
    for (int i = 0; i < nb; i++) begin
      if (gaps)
        while ($urandom_range(0, 2) == 0)
          step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom));
      step(1'b1, v[i*8 +: 8], (i == last_pos), gaps ? 1'($urandom) : 1'b0, 6'($urandom));
    end
  endtask

  task automatic lookup_all(input bit gaps);
    for (int a = 0; a < 64; a++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      step(1'b0, 8'($urandom), 1'b0, 1'b1, 6'(a));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
    in_valid = 1'b0; in_data = '0;
    mtbl = '0; mcnt = 0; mloaded = 1'b0;

    // Reset values and cfg_ready latency
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_tbl_loaded", tbl_loaded, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    #1;
    chk("cfg_ready_first_cycle", cfg_ready, 0);
    @(posedge clk);
    #1;
    chk("cfg_ready_after_release", cfg_ready, 1);

    // Lookups with no table are dropped
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 6'($urandom));

    // Reference table: entries 14 and 63 set
    load(64'h8000_0000_0000_4000, 7, 8, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 6'd14);
    step(1'b0, 8'h00, 1'b0, 1'b1, 6'd63);
    step(1'b0, 8'h00, 1'b0, 1'b1, 6'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 6'd13);
    idle(2);

    // Early cfg_last, then a clean load
    load({$urandom, $urandom}, 3, 4, 1'b0);
    idle(1);
    load({$urandom, $urandom}, 7, 8, 1'b0);
    lookup_all(1'b0);
    // Missing cfg_last, then a clean load
    load({$urandom, $urandom}, -1, 8, 1'b0);
    idle(1);
    load({$urandom, $urandom}, 7, 8, 1'b0);
    idle(1);

    // Load with random gaps and lookups interleaved; entry 63 forced to 1
    v = {$urandom, $urandom};
    v[63] = 1'b1;
    load(v, 7, 8, 1'b1);
    lookup_all(1'b1);

    // Reload from RUN: same-cycle lookup of 63 sees the old table
    step(1'b1, 8'hFF, 1'b0, 1'b1, 6'd63);
    for (int i = 1; i < NB; i++) step(1'b1, 8'hFF, (i == NB - 1), 1'b1, 6'($urandom));
    lookup_all(1'b0);
    idle(2);

    // Reset in the middle of a load
    v = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) step(1'b1, v[i*8 +: 8], 1'b0, 1'b0, 6'd0);
    idle(2);
    step(1'b1, v[39:32], 1'b0, 1'b0, 6'd0);
    rst_n = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0;
    #1;
    chk("midload_rst_tbl_loaded", tbl_loaded, 0);
    chk("midload_rst_cfg_ready", cfg_ready, 0);
    chk("midload_rst_out_valid", out_valid, 0);
    mcnt = 0; mloaded = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    chk("cfg_ready_after_midload_rst", cfg_ready, 1);
    load({$urandom, $urandom}, 7, 8, 1'b1);
    lookup_all(1'b1);
    for (int i = 0; i < 32; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 6'($urandom));

    idle(3);
    chk("scoreboard_drain", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
